// File: rtl/fb_arbiter.sv
// Double-buffered framebuffer arbiter: shares one SRAM port between
// VGA reads (priority) and queued renderer writes, with vsync-timed swap.
module fb_arbiter (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        wr_req,
  input  logic [9:0]  wr_x,
  input  logic [9:0]  wr_y,
  input  logic [15:0] wr_data,
  output logic        wr_ready,
  input  logic        rd_req,
  input  logic [9:0]  rd_x,
  input  logic [9:0]  rd_y,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  input  logic        frame_done,
  input  logic        vsync_start,
  output logic        render_enable,
  output logic        swap_pending,
  output logic        front_sel,
  output logic [19:0] sram_addr,
  output logic [15:0] sram_wdata,
  input  logic [15:0] sram_rdata,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n
);

  typedef enum logic [1:0] {
    RENDER,
    DRAIN,
    WAIT_VSYNC
  } state_t;

  state_t state, state_nx;

  logic [9:0]  fx [4];
  logic [9:0]  fy [4];
  logic [15:0] fd [4];
  logic [1:0]  wr_ptr, rd_ptr;
  logic [2:0]  count;

  logic rd_hit, wr_in, push, pop, swap;

  assign rd_hit   = rd_req && (rd_x < 10'd640) && (rd_y < 10'd480);
  assign wr_in    = (wr_x < 10'd640) && (wr_y < 10'd480);
  assign wr_ready = (count < 3'd4) && (state != WAIT_VSYNC);
  assign push     = wr_req && wr_ready && wr_in && !Reset;
  assign pop      = (count != 3'd0) && !rd_hit && !Reset;

  assign render_enable = (state == RENDER);
  assign swap_pending  = (state != RENDER);

  // Write FIFO storage and pointers; reset drops queued pixels.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fx[wr_ptr] <= wr_x;
        fy[wr_ptr] <= wr_y;
        fd[wr_ptr] <= wr_data;
        wr_ptr     <= wr_ptr + 2'd1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 2'd1;
      count <= count + {2'b0, push} - {2'b0, pop};
    end
  end

  // SRAM port mux: read wins, otherwise drain FIFO head, else idle.
  always_comb begin
    sram_ce_n  = 1'b1;
    sram_oe_n  = 1'b1;
    sram_we_n  = 1'b1;
    sram_addr  = '0;
    sram_wdata = '0;
    if (!Reset && rd_hit) begin
      sram_ce_n = 1'b0;
      sram_oe_n = 1'b0;
      sram_addr = {front_sel, rd_y[8:0], rd_x};
    end else if (pop) begin
      sram_ce_n  = 1'b0;
      sram_we_n  = 1'b0;
      sram_addr  = {~front_sel, fy[rd_ptr][8:0], fx[rd_ptr]};
      sram_wdata = fd[rd_ptr];
    end
  end

  // Read return: one cycle after the request, zero when out of range.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req)
        rd_data <= rd_hit ? sram_rdata : 16'h0;
    end
  end

  // Swap FSM next-state.
  always_comb begin
    state_nx = state;
    swap     = 1'b0;
    unique case (state)
      RENDER:
        if (frame_done)
          state_nx = DRAIN;
      DRAIN:
        if (count == 3'd0 && !push)
          state_nx = WAIT_VSYNC;
      WAIT_VSYNC:
        if (vsync_start) begin
          swap     = 1'b1;
          state_nx = RENDER;
        end
      default:
        state_nx = RENDER;
    endcase
  end

  // FSM state and displayed-buffer select.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= RENDER;
      front_sel <= 1'b0;
    end else begin
      state     <= state_nx;
      front_sel <= front_sel ^ swap;
    end
  end

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter: reset, writes, reads, FIFO
// backpressure, buffer swap and mid-drain reset.
module tb_fb_arbiter;

  logic        Clk = 0;
  logic        Reset;
  logic        wr_req;
  logic [9:0]  wr_x, wr_y;
  logic [15:0] wr_data;
  logic        wr_ready;
  logic        rd_req;
  logic [9:0]  rd_x, rd_y;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        frame_done, vsync_start;
  logic        render_enable, swap_pending, front_sel;
  logic [19:0] sram_addr;
  logic [15:0] sram_wdata, sram_rdata;
  logic        sram_ce_n, sram_oe_n, sram_we_n;

  int n_chk = 0;
  int n_fail = 0;

  always #5 Clk = ~Clk;

  fb_arbiter dut (
    .Clk(Clk), .Reset(Reset),
    .wr_req(wr_req), .wr_x(wr_x), .wr_y(wr_y),
    .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_req(rd_req), .rd_x(rd_x), .rd_y(rd_y),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .frame_done(frame_done), .vsync_start(vsync_start),
    .render_enable(render_enable),
    .swap_pending(swap_pending), .front_sel(front_sel),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata), .sram_ce_n(sram_ce_n),
    .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
  );

  task automatic step;
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset;
    Reset = 1;
    step;
    step;
    #3;
    n_chk++;
    if (sram_ce_n !== 1'b1 || sram_addr !== 20'h0) begin
      n_fail++;
      $display("FAIL rst_strobe: ce_n=%b addr=%h want 1/0", sram_ce_n, sram_addr);
    end
    n_chk++;
    if ({render_enable, swap_pending, front_sel} !== 3'b100) begin
      n_fail++;
      $display("FAIL rst_fsm: got %b want 100", {render_enable, swap_pending, front_sel});
    end
    n_chk++;
    if (rd_valid !== 1'b0 || rd_data !== 16'h0) begin
      n_fail++;
      $display("FAIL rst_rd: valid=%b data=%h want 0/0", rd_valid, rd_data);
    end
    n_chk++;
    if (wr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_wr_ready: got %b want 1", wr_ready);
    end
    Reset = 0;
    step;
  endtask

  task automatic test_single_write;
    wr_req = 1; wr_x = 10'd5; wr_y = 10'd2; wr_data = 16'hABCD;
    #3;
    n_chk++;
    if (wr_ready !== 1'b1 || sram_ce_n !== 1'b1) begin
      n_fail++;
      $display("FAIL sw_accept: ready=%b ce_n=%b want 1/1", wr_ready, sram_ce_n);
    end
    step;
    wr_req = 0;
    #3;
    n_chk++;
    if (sram_addr !== 20'h80805 || sram_wdata !== 16'hABCD) begin
      n_fail++;
      $display("FAIL sw_addr: addr=%h wdata=%h want 80805/abcd", sram_addr, sram_wdata);
    end
    n_chk++;
    if ({sram_ce_n, sram_oe_n, sram_we_n} !== 3'b010) begin
      n_fail++;
      $display("FAIL sw_strobe: got %b want 010", {sram_ce_n, sram_oe_n, sram_we_n});
    end
    step;
    #3;
    n_chk++;
    if ({sram_ce_n, sram_oe_n, sram_we_n} !== 3'b111 || sram_addr !== 20'h0) begin
      n_fail++;
      $display("FAIL sw_idle: strobes=%b addr=%h want 111/0", {sram_ce_n, sram_oe_n, sram_we_n}, sram_addr);
    end
    step;
  endtask

  task automatic test_read;
    rd_req = 1; rd_x = 10'd10; rd_y = 10'd0; sram_rdata = 16'h1234;
    #3;
    n_chk++;
    if ({sram_ce_n, sram_oe_n, sram_we_n} !== 3'b001 || sram_addr !== 20'h0000A) begin
      n_fail++;
      $display("FAIL rd_strobe: strobes=%b addr=%h want 001/0000a", {sram_ce_n, sram_oe_n, sram_we_n}, sram_addr);
    end
    step;
    rd_x = 10'd700; sram_rdata = 16'h5678;
    #3;
    n_chk++;
    if (rd_valid !== 1'b1 || rd_data !== 16'h1234) begin
      n_fail++;
      $display("FAIL rd_data: valid=%b data=%h want 1/1234", rd_valid, rd_data);
    end
    n_chk++;
    if (sram_ce_n !== 1'b1) begin
      n_fail++;
      $display("FAIL rd_oor_strobe: ce_n=%b want 1", sram_ce_n);
    end
    step;
    rd_req = 0;
    #3;
    n_chk++;
    if (rd_valid !== 1'b1 || rd_data !== 16'h0) begin
      n_fail++;
      $display("FAIL rd_oor_data: valid=%b data=%h want 1/0000", rd_valid, rd_data);
    end
    step;
    #3;
    n_chk++;
    if (rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_valid_pulse: got %b want 0", rd_valid);
    end
    step;
  endtask

  task automatic test_back_to_back;
    rd_req = 1; rd_x = 10'd1; rd_y = 10'd1;
    for (int i = 0; i < 4; i++) begin
      wr_req = 1; wr_x = 10'(i); wr_y = 10'd3;
      wr_data = 16'h1000 + 16'(i);
      #3;
      n_chk++;
      if (wr_ready !== 1'b1 || sram_we_n !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_push%0d: ready=%b we_n=%b want 1/1", i, wr_ready, sram_we_n);
      end
      step;
    end
    wr_x = 10'd4; wr_data = 16'h1004;
    #3;
    n_chk++;
    if (wr_ready !== 1'b0 || sram_we_n !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_full: ready=%b we_n=%b want 0/1", wr_ready, sram_we_n);
    end
    step;
    wr_req = 0; rd_req = 0;
    for (int i = 0; i < 4; i++) begin
      #3;
      n_chk++;
      if (sram_we_n !== 1'b0 || sram_addr !== 20'h80C00 + 20'(i)
          || sram_wdata !== 16'h1000 + 16'(i)) begin
        n_fail++;
        $display("FAIL b2b_drain%0d: we_n=%b addr=%h wdata=%h want 0/%h/%h", i, sram_we_n, sram_addr, sram_wdata, 20'h80C00 + 20'(i), 16'h1000 + 16'(i));
      end
      step;
    end
    #3;
    n_chk++;
    if (sram_ce_n !== 1'b1 || dut.count !== 3'd0) begin
      n_fail++;
      $display("FAIL b2b_empty: ce_n=%b count=%0d want 1/0", sram_ce_n, dut.count);
    end
    step;
  endtask

  task automatic test_oor_write;
    wr_req = 1; wr_x = 10'd640; wr_y = 10'd0; wr_data = 16'h5555;
    #3;
    n_chk++;
    if (wr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL oorw_ready: got %b want 1", wr_ready);
    end
    step;
    wr_req = 0;
    #3;
    n_chk++;
    if (dut.count !== 3'd0 || sram_ce_n !== 1'b1) begin
      n_fail++;
      $display("FAIL oorw_drop: count=%0d ce_n=%b want 0/1", dut.count, sram_ce_n);
    end
    step;
  endtask

  task automatic test_swap;
    rd_req = 1; rd_x = 10'd2; rd_y = 10'd2;
    wr_req = 1; wr_x = 10'd7; wr_y = 10'd1; wr_data = 16'h2222;
    step;
    wr_x = 10'd8; wr_data = 16'h3333;
    step;
    wr_req = 0; frame_done = 1;
    step;
    frame_done = 0; vsync_start = 1;
    #3;
    n_chk++;
    if (swap_pending !== 1'b1 || render_enable !== 1'b0 || dut.count !== 3'd2) begin
      n_fail++;
      $display("FAIL sw_drain: pend=%b ren=%b count=%0d want 1/0/2", swap_pending, render_enable, dut.count);
    end
    step;
    vsync_start = 0; rd_req = 0;
    #3;
    n_chk++;
    if (sram_we_n !== 1'b0 || sram_addr !== 20'h80407 || sram_wdata !== 16'h2222) begin
      n_fail++;
      $display("FAIL sw_wr0: we_n=%b addr=%h wdata=%h want 0/80407/2222", sram_we_n, sram_addr, sram_wdata);
    end
    step;
    #3;
    n_chk++;
    if (sram_addr !== 20'h80408 || sram_wdata !== 16'h3333 || front_sel !== 1'b0) begin
      n_fail++;
      $display("FAIL sw_wr1: addr=%h wdata=%h front=%b want 80408/3333/0", sram_addr, sram_wdata, front_sel);
    end
    step;
    #3;
    n_chk++;
    if (swap_pending !== 1'b1 || sram_ce_n !== 1'b1) begin
      n_fail++;
      $display("FAIL sw_last_drain: pend=%b ce_n=%b want 1/1", swap_pending, sram_ce_n);
    end
    step;
    vsync_start = 1; rd_req = 1; rd_x = 10'd3; rd_y = 10'd0;
    #3;
    n_chk++;
    if (wr_ready !== 1'b0 || sram_addr !== 20'h00003 || sram_oe_n !== 1'b0) begin
      n_fail++;
      $display("FAIL sw_wait: ready=%b addr=%h oe_n=%b want 0/00003/0", wr_ready, sram_addr, sram_oe_n);
    end
    step;
    vsync_start = 0;
    #3;
    n_chk++;
    if ({front_sel, render_enable, swap_pending, wr_ready} !== 4'b1101) begin
      n_fail++;
      $display("FAIL sw_swapped: got %b want 1101", {front_sel, render_enable, swap_pending, wr_ready});
    end
    n_chk++;
    if (sram_addr !== 20'h80003) begin
      n_fail++;
      $display("FAIL sw_new_front: addr=%h want 80003", sram_addr);
    end
    step;
    rd_req = 0;
    step;
  endtask

  task automatic test_reset_mid;
    rd_req = 1; rd_x = 10'd0; rd_y = 10'd0;
    for (int i = 0; i < 3; i++) begin
      wr_req = 1; wr_x = 10'(i); wr_y = 10'd9; wr_data = 16'(i);
      step;
    end
    wr_req = 0; frame_done = 1;
    step;
    frame_done = 0;
    #3;
    n_chk++;
    if (swap_pending !== 1'b1 || dut.count !== 3'd3) begin
      n_fail++;
      $display("FAIL rm_pre: pend=%b count=%0d want 1/3", swap_pending, dut.count);
    end
    Reset = 1;
    #1;
    n_chk++;
    if ({sram_ce_n, sram_oe_n, sram_we_n} !== 3'b111) begin
      n_fail++;
      $display("FAIL rm_strobe: got %b want 111", {sram_ce_n, sram_oe_n, sram_we_n});
    end
    step;
    Reset = 0; rd_req = 0;
    #3;
    n_chk++;
    if (dut.count !== 3'd0 || sram_ce_n !== 1'b1) begin
      n_fail++;
      $display("FAIL rm_fifo: count=%0d ce_n=%b want 0/1", dut.count, sram_ce_n);
    end
    n_chk++;
    if ({render_enable, swap_pending, front_sel, rd_valid} !== 4'b1000) begin
      n_fail++;
      $display("FAIL rm_state: got %b want 1000", {render_enable, swap_pending, front_sel, rd_valid});
    end
    step;
  endtask

  initial begin
    Reset = 1; wr_req = 0; wr_x = 0; wr_y = 0; wr_data = 0;
    rd_req = 0; rd_x = 0; rd_y = 0; sram_rdata = 0;
    frame_done = 0; vsync_start = 0;
    test_reset;
    test_single_write;
    test_read;
    test_back_to_back;
    test_oor_write;
    test_swap;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
